// File: rtl/tv_pkg.sv
// tv_pkg: shared types and vector-field layout for the tv_sequencer test-vector player.
// Optional feature: TV_SEQUENCER_MASK_EN adds a per-vector compare mask field.
// Vector layout (MSB first): {skip, stim, [mask,] exp}.
package tv_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    FIN    = 3'd4
  } state_t;
  localparam int ERR_W = 16;
`ifdef TV_SEQUENCER_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif
  function automatic int vec_w(input int out_w, input int in_w);
    return 1 + out_w + (MASK_EN ? 2 : 1) * in_w;
  endfunction
  function automatic int exp_lsb();
    return 0;
  endfunction
  function automatic int mask_lsb(input int in_w);
    return in_w;
  endfunction
  function automatic int stim_lsb(input int in_w);
    return MASK_EN ? 2 * in_w : in_w;
  endfunction
  function automatic int skip_pos(input int out_w, input int in_w);
    return vec_w(out_w, in_w) - 1;
  endfunction
endpackage

// File: rtl/tv_sync.sv
// tv_sync: STAGES-deep flop chain bringing the asynchronous fabric response into the clock domain.
// Ports: clk, rst_n (synchronous active-low clear), d (async input), q (synchronised output).
module tv_sync #(
  parameter int W      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] ff [STAGES];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff <= '{default: '0};
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end
  assign q = ff[STAGES-1];
endmodule

// File: rtl/tv_sequencer.sv
// tv_sequencer: on-chip test-vector player/checker for the asynchronous fabric.
// Ports: wb_clk_i/wb_rst_i (sync active-low reset), ld_* vector load port, start/abort/
// stop_on_err/num_vec/settle run control, stim_o/resp_i fabric interface, busy/done/
// err_cnt/first_err/err_seen/vec_idx status.
// Optional feature: TV_SEQUENCER_MASK_EN enables a per-vector response compare mask.
module tv_sequencer
  import tv_pkg::*;
#(
  parameter int OUT_W       = 32,
  parameter int IN_W        = 32,
  parameter int DEPTH       = 64,
  parameter int AW          = $clog2(DEPTH),
  parameter int SETTLE_W    = 8,
  parameter int SYNC_STAGES = 2,
  localparam int VW         = vec_w(OUT_W, IN_W)
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                ld_we,
  input  logic [AW-1:0]       ld_addr,
  input  logic [VW-1:0]       ld_data,
  input  logic                start,
  input  logic                abort,
  input  logic                stop_on_err,
  input  logic [AW:0]         num_vec,
  input  logic [SETTLE_W-1:0] settle,
  output logic [OUT_W-1:0]    stim_o,
  input  logic [IN_W-1:0]     resp_i,
  output logic                busy,
  output logic                done,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [AW-1:0]       first_err,
  output logic                err_seen,
  output logic [AW:0]         vec_idx
);
  localparam int SKIP = skip_pos(OUT_W, IN_W);
  localparam int STIM = stim_lsb(IN_W);
  localparam int EXP  = exp_lsb();
  // Shortest SETTLE load that still lets the new response cross the synchroniser.
  localparam logic [SETTLE_W-1:0] MIN_WAIT = SETTLE_W'(SYNC_STAGES - 1);
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);
  logic [VW-1:0]       mem [DEPTH];
  logic [VW-1:0]       vec;
  state_t              state;
  logic                cur_skip;
  logic [IN_W-1:0]     cur_exp;
  logic [IN_W-1:0]     resp_sync;
  logic [SETTLE_W-1:0] cnt;
  logic [AW:0]         nv;
  logic [AW:0]         idx_nx;
  logic                abort_q;
  logic                mismatch;
  tv_sync #(.W(IN_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (wb_clk_i),
    .rst_n(wb_rst_i),
    .d    (resp_i),
    .q    (resp_sync)
  );
  always_ff @(posedge wb_clk_i) if (ld_we) mem[ld_addr] <= ld_data;
  assign vec    = mem[vec_idx[AW-1:0]];
  assign idx_nx = vec_idx + 1'b1;
`ifdef TV_SEQUENCER_MASK_EN
  localparam int MASK = mask_lsb(IN_W);
  logic [IN_W-1:0] cur_mask;
  always_ff @(posedge wb_clk_i) if (state == APPLY) cur_mask <= vec[MASK +: IN_W];
  assign mismatch = !cur_skip && (((resp_sync ^ cur_exp) & cur_mask) != '0);
`else
  assign mismatch = !cur_skip && (resp_sync != cur_exp);
`endif
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state     <= IDLE;
      stim_o    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
      first_err <= '0;
      err_seen  <= 1'b0;
      vec_idx   <= '0;
      cur_skip  <= 1'b0;
      cur_exp   <= '0;
      cnt       <= '0;
      nv        <= '0;
      abort_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= (num_vec == '0) ? FIN : APPLY;
          busy      <= 1'b1;
          err_cnt   <= '0;
          err_seen  <= 1'b0;
          first_err <= '0;
          vec_idx   <= '0;
          abort_q   <= 1'b0;
          nv        <= (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
        end
        APPLY: begin
          cur_skip <= vec[SKIP];
          cur_exp  <= vec[EXP +: IN_W];
          stim_o   <= vec[STIM +: OUT_W];
          cnt      <= (settle < MIN_WAIT) ? MIN_WAIT : settle;
          state    <= SETTLE;
        end
        SETTLE: begin
          abort_q <= abort_q | abort;
          cnt     <= cnt - 1'b1;
          if (cnt == '0) state <= (abort_q | abort) ? FIN : CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            err_cnt <= (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
            if (!err_seen) begin
              err_seen  <= 1'b1;
              first_err <= vec_idx[AW-1:0];
            end
          end
          vec_idx <= idx_nx;
          state   <= ((mismatch && stop_on_err) || idx_nx == nv || abort_q || abort) ? FIN : APPLY;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tv_sequencer.sv
// tb_tv_sequencer: scoreboard bench for tv_sequencer with fabric loopback (resp_i = stim_o).
module tb_tv_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int OUT_W = 32;
  localparam int IN_W  = 32;
`ifdef TV_SEQUENCER_MASK_EN
  localparam bit MASK_ON = 1'b1;
  localparam int VW      = 1 + OUT_W + 2 * IN_W;
`else
  localparam bit MASK_ON = 1'b0;
  localparam int VW      = 1 + OUT_W + IN_W;
`endif
  typedef struct packed {
    logic [15:0] cnt;
    logic        seen;
    logic [2:0]  first;
    logic [3:0]  idx;
    logic [31:0] stim;
  } exp_t;
  logic clk = 0, rst_n = 0, ld_we = 0, start = 0, start3 = 0, abort = 0, soe = 0;
  logic [AW-1:0] ld_addr = '0;
  logic [VW-1:0] ld_data = '0;
  logic [AW:0]   num_vec = '0;
  logic [7:0]    settle = '0;
  logic [31:0] stim_o, stim3;
  logic        busy, done, err_seen, busy3, done3, seen3;
  logic [15:0] err_cnt, err3;
  logic [2:0]  first_err, first3;
  logic [3:0]  vec_idx, idx3;
  logic        m_skip [DEPTH];
  logic [31:0] m_stim [DEPTH];
  logic [31:0] m_mask [DEPTH];
  logic [31:0] m_exp  [DEPTH];
  exp_t q[$];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  tv_sequencer #(.OUT_W(OUT_W), .IN_W(IN_W), .DEPTH(DEPTH), .SETTLE_W(8), .SYNC_STAGES(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .abort(abort), .stop_on_err(soe), .num_vec(num_vec), .settle(settle),
    .stim_o(stim_o), .resp_i(stim_o), .busy(busy), .done(done), .err_cnt(err_cnt),
    .first_err(first_err), .err_seen(err_seen), .vec_idx(vec_idx)
  );
  tv_sequencer #(.OUT_W(OUT_W), .IN_W(IN_W), .DEPTH(DEPTH), .SETTLE_W(8), .SYNC_STAGES(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start3), .abort(1'b0), .stop_on_err(soe), .num_vec(num_vec), .settle(settle),
    .stim_o(stim3), .resp_i(stim3), .busy(busy3), .done(done3), .err_cnt(err3),
    .first_err(first3), .err_seen(seen3), .vec_idx(idx3)
  );
  task automatic load(input int i, input logic sk, input logic [31:0] st, input logic [31:0] mk, input logic [31:0] ex);
    m_skip[i] = sk; m_stim[i] = st; m_mask[i] = mk; m_exp[i] = ex;
    ld_addr = AW'(i);
`ifdef TV_SEQUENCER_MASK_EN
    ld_data = {sk, st, mk, ex};
`else
    ld_data = {sk, st, ex};
`endif
    ld_we = 1;
    @(negedge clk);
    ld_we = 0;
  endtask
  task automatic load_loop();
    logic [31:0] s;
    for (int i = 0; i < DEPTH; i++) begin
      s = {8'(i + 1), 24'($urandom)};
      load(i, 1'b0, s, 32'hFFFF_FFFF, s);
    end
  endtask
  function automatic exp_t model(input int n, input bit so);
    exp_t e;
    int nn;
    logic mm;
    e = '{default: '0};
    nn = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < nn; i++) begin
      mm = !m_skip[i] && (((m_stim[i] ^ m_exp[i]) & (MASK_ON ? m_mask[i] : 32'hFFFF_FFFF)) != 0);
      e.stim = m_stim[i];
      e.idx = 4'(i + 1);
      if (mm) begin
        e.cnt = e.cnt + 1;
        if (!e.seen) begin e.seen = 1; e.first = 3'(i); end
      end
      if (mm && so) break;
    end
    return e;
  endfunction
  task automatic run(input string nm, input int n, input int st, input bit so, input bit u3, input int exp_cyc);
    exp_t e, o;
    int c;
    q.push_back(model(n, so));
    num_vec = (AW + 1)'(n); settle = 8'(st); soe = so;
    if (u3) start3 = 1; else start = 1;
    @(negedge clk);
    start = 0; start3 = 0; c = 1;
    while (!(u3 ? done3 : done) && c < 3000) begin @(negedge clk); c++; end
    e = q.pop_front();
    o.cnt = u3 ? err3 : err_cnt; o.seen = u3 ? seen3 : err_seen; o.first = u3 ? first3 : first_err;
    o.idx = u3 ? idx3 : vec_idx; o.stim = u3 ? stim3 : stim_o;
    n_cmp++;
    if (c >= 3000) begin
      n_err++; $display("FAIL %s timeout: no done after %0d cycles", nm, c);
    end else if (o !== e) begin
      n_err++;
      $display("FAIL %s got cnt=%0d seen=%0d first=%0d idx=%0d stim=%h want cnt=%0d seen=%0d first=%0d idx=%0d stim=%h",
               nm, o.cnt, o.seen, o.first, o.idx, o.stim, e.cnt, e.seen, e.first, e.idx, e.stim);
    end
    if (exp_cyc >= 0) begin
      n_cmp++;
      if (c !== exp_cyc) begin n_err++; $display("FAIL %s latency got %0d want %0d", nm, c, exp_cyc); end
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({stim_o, busy, done, err_cnt, first_err, err_seen, vec_idx} !== '0) begin
      n_err++;
      $display("FAIL reset got stim=%h busy=%b done=%b err=%0d first=%0d seen=%b idx=%0d want all 0",
               stim_o, busy, done, err_cnt, first_err, err_seen, vec_idx);
    end
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_loopback();
    load_loop();
    run("loopback", 4, 3, 0, 0, 2 + 4 * 6);
    run("back_to_back", 2, 1, 0, 0, 2 + 2 * 4);
  endtask
  task automatic test_mismatch();
    load(2, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    run("mismatch", 4, 3, 0, 0, 2 + 4 * 6);
    run("stop_on_err", 4, 3, 1, 0, -1);
  endtask
  task automatic test_skip_mask();
    load_loop();
    load(1, 1'b1, m_stim[1], 32'hFFFF_FFFF, ~m_stim[1]);
    load(3, 1'b0, m_stim[3], 32'h0000_FFFF, m_stim[3] ^ 32'hABCD_0000);
    run("skip_mask", 4, 2, 0, 0, -1);
  endtask
  task automatic test_zero_vec();
    num_vec = '0; start = 1;
    @(negedge clk);
    start = 0;
    n_cmp++;
    if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL zero_vec c1 got busy=%b done=%b want 1 0", busy, done); end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, err_cnt, vec_idx} !== {2'b01, 16'd0, 4'd0}) begin
      n_err++; $display("FAIL zero_vec c2 got busy=%b done=%b err=%0d idx=%0d want 0 1 0 0", busy, done, err_cnt, vec_idx);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL zero_vec c3 done got %b want 0", done); end
  endtask
  task automatic test_clamp();
    load_loop();
    run("full_depth", 8, 0, 0, 0, 2 + 8 * 4);
    run("clamp", 15, 0, 0, 0, 2 + 8 * 4);
  endtask
  task automatic test_settle_min();
    run("sync3_settle0", 8, 0, 0, 1, 2 + 8 * 5);
    run("sync3_settle1", 3, 1, 0, 1, 2 + 3 * 5);
    run("sync3_settle4", 2, 4, 0, 1, 2 + 2 * 7);
  endtask
  task automatic test_abort();
    int c;
    num_vec = 4'd4; settle = 8'd10; soe = 0; start = 1;
    @(negedge clk);
    start = 0; c = 0;
    while (stim_o !== m_stim[1] && c < 200) begin @(negedge clk); c++; end
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0; c = 0;
    while (!done && c < 200) begin @(negedge clk); c++; end
    n_cmp++;
    if (!done || vec_idx !== 4'd1 || err_cnt !== 16'd0 || stim_o !== m_stim[1]) begin
      n_err++; $display("FAIL abort got done=%b idx=%0d err=%0d stim=%h want 1 1 0 %h", done, vec_idx, err_cnt, stim_o, m_stim[1]);
    end
    @(negedge clk);
  endtask
  task automatic test_reset_midrun();
    int c, dn;
    num_vec = 4'd4; settle = 8'd20; soe = 0; start = 1;
    @(negedge clk);
    start = 0; c = 0;
    while (stim_o !== m_stim[1] && c < 200) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    n_cmp++;
    if ({busy, stim_o, err_cnt, done} !== '0) begin
      n_err++; $display("FAIL reset_midrun got busy=%b stim=%h err=%0d done=%b want 0", busy, stim_o, err_cnt, done);
    end
    dn = 0;
    repeat (60) begin @(negedge clk); dn += int'(done); end
    n_cmp++;
    if (dn !== 0) begin n_err++; $display("FAIL reset_no_done got %0d done pulses want 0", dn); end
    run("mem_retained", 4, 1, 0, 0, 2 + 4 * 4);
  endtask
  initial begin
    test_reset();
    test_loopback();
    test_mismatch();
    test_zero_vec();
    test_skip_mask();
    test_clamp();
    test_settle_min();
    test_abort();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tv_sequencer.md
Name: tv_sequencer

Overview:
- Synthesizable, parametrised on-chip test-vector player/checker for the asynchronous Morphle fabric (pnet/yblock) in the user project area.
- Stores DEPTH vectors, each holding stimulus, expected response and a skip-check flag.
- Drives the stimulus onto the fabric, waits a programmable settle time, samples the synchronised response and counts mismatches.
- Replaces host-side vector driving over the logic analyzer.

Parameters:
- OUT_W, 32, stimulus width driven into the fabric
- IN_W, 32, response width sampled from the fabric
- DEPTH, 64, vector storage entries; power of two
- AW, $clog2(DEPTH), address and index width
- SETTLE_W, 8, width of the settle-cycle counter
- SYNC_STAGES, 2, response synchroniser depth; 2 or greater

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  reset, synchronous, active-low
- ld_we  in  1  write one vector entry this cycle
- ld_addr  in  AW  entry address
- ld_data  in  1+OUT_W+IN_W  {skip, stim, exp}, with skip in the MSB
- start  in  1  pulse; begins a run when idle
- abort  in  1  ends the current run at the next state boundary
- stop_on_err  in  1  halt at the first mismatch
- num_vec  in  AW+1  vectors to run; 0 means none
- settle  in  SETTLE_W  wait cycles after applying stimulus
- stim_o  out  OUT_W  stimulus to the fabric
- resp_i  in  IN_W  asynchronous fabric response
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- err_cnt  out  16  saturating mismatch count
- first_err  out  AW  index of the first mismatch
- err_seen  out  1  at least one mismatch in this run
- vec_idx  out  AW+1  current or final vector index

Behaviour:
- Reset (wb_rst_i==0 sampled at a clock edge):
  - state=IDLE.
  - stim_o, busy, done, err_cnt, first_err, err_seen, vec_idx all 0.
  - Synchroniser flops cleared.
  - Vector memory is not cleared.
  - Reset during a run abandons it; no done pulse.
- Memory writes:
  - ld_we writes mem[ld_addr] on the clock edge.
  - Writes are accepted in any state. A write to the entry being executed takes effect on the next read only; the active vector is latched in APPLY.
- States are IDLE, APPLY, SETTLE, CHECK, FIN.
- IDLE:
  - start with num_vec!=0 → APPLY; clears err_cnt, err_seen, first_err and vec_idx; busy=1.
  - start with num_vec==0 → FIN directly; err_cnt stays 0.
  - start while busy is ignored.
- APPLY (1 cycle):
  - Latch mem[vec_idx] into cur.
  - stim_o <= cur.stim, registered and glitch-free.
  - Load the wait counter with settle → SETTLE.
- SETTLE:
  - Counter decrements each cycle; on reaching 0 → CHECK.
  - settle==0 gives one SETTLE cycle.
  - The sampled response always has passed SYNC_STAGES flops after the stim_o update. Minimum apply-to-sample time is max(settle+1, SYNC_STAGES) cycles; the implementation extends the wait when settle+1 < SYNC_STAGES.
- CHECK (1 cycle):
  - mismatch = !cur.skip && (resp_sync != cur.exp).
  - On mismatch: err_cnt+1, saturating at 16'hFFFF. If err_seen was 0, set it and load first_err=vec_idx.
  - vec_idx+1. Then:
    - (mismatch && stop_on_err) or vec_idx+1==num_vec → FIN.
    - Otherwise → APPLY.
- FIN (1 cycle):
  - done=1, busy=0 → IDLE.
  - stim_o holds its last value.
  - On a stop_on_err halt, vec_idx points one past the failing vector.
- abort: sampled in SETTLE and CHECK; forces FIN after the current state finishes. A CHECK still performs its compare. done pulses.
- Wrap-around: num_vec==DEPTH runs every entry. Values above DEPTH are clamped to DEPTH.
- Simultaneous start and abort in IDLE: start wins; abort is ignored.

Optional Feature:
- Macro: TV_SEQUENCER_MASK_EN.
- When defined:
  - ld_data widens to 1+OUT_W+2*IN_W as {skip, stim, mask, exp}.
  - A response bit is compared only where its mask bit is 1: mismatch = !skip && ((resp ^ exp) & mask) != 0.
- When undefined: the mask field does not exist and all IN_W bits are compared.

Decomposition:
- Package tv_pkg:
  - state encoding constants (IDLE=0, APPLY=1, SETTLE=2, CHECK=3, FIN=4)
  - err_cnt width constant (16)
  - vector-field offset macros for skip, stim, mask and exp
- Sub-module tv_sync: a SYNC_STAGES-deep, IN_W-wide flop chain with synchronous active-low clear, instantiated on resp_i.

Test Plan:
- Load 4 vectors whose exp equals stim and loop stim_o back to resp_i; num_vec=4, settle=3 → done after 4 vectors; err_cnt=0, err_seen=0, vec_idx=4.
- Same loopback, but vector 2 has exp=32'hDEADBEEF and stim=0; stop_on_err=0 → err_cnt=1, first_err=2, vec_idx=4.
- Same as the previous case with stop_on_err=1 → done asserts after vector 2; vec_idx=3; stim_o holds vector 2's stimulus.
- Vector 1 mismatches but has skip=1 → err_cnt=0. With TV_SEQUENCER_MASK_EN, mask=32'h0000FFFF and a resp difference only in the upper 16 bits → err_cnt=0.
- wb_rst_i=0 during SETTLE of vector 1 → the next cycle shows busy=0, stim_o=0, err_cnt=0, and no done pulse.
- Edge cases:
  - num_vec=0 with start → a single done pulse 2 cycles later; busy is high for 1 cycle.
  - settle=0 with SYNC_STAGES=3 → the response is sampled no earlier than 3 cycles after the stim_o update.
